// File: rtl/lagd_analog_pkg.sv
// -----------------------------------------------------------------------------
// lagd_analog_pkg
// Shared types and helpers for the analog weight configuration path.
//   CntWidth            : default width of the phase counters
//   MaxRows             : largest analog array depth the row helpers support
//   row_idx_t           : row index type (wide enough for MaxRows rows)
//   analog_wcfg_state_e : sequencer state encoding (also exported for debug)
//   row_onehot()        : row index -> one-hot row select
// -----------------------------------------------------------------------------
package lagd_analog_pkg;

    localparam int unsigned CntWidth = 32;
    localparam int unsigned MaxRows  = 256;

    typedef logic [$clog2(MaxRows)-1:0] row_idx_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        HIGH  = 3'd3,
        LOW   = 3'd4,
        DONE  = 3'd5
    } analog_wcfg_state_e;

    function automatic logic [MaxRows-1:0] row_onehot(input row_idx_t row);
        logic [MaxRows-1:0] sel;
        sel      = '0;
        sel[row] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/analog_phase_cnt.sv
// -----------------------------------------------------------------------------
// analog_phase_cnt
// Loadable down-counter shared by the HIGH and LOW phases of the sequencer.
// Load has priority; when enabled the count decrements and saturates at zero.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i        : load load_val_i this cycle
//   en_i          : decrement enable
//   load_val_i    : value to load (phase length minus one)
//   zero_o        : count is zero (last cycle of the current phase)
// -----------------------------------------------------------------------------
module analog_phase_cnt
    import lagd_analog_pkg::*;
#(
    parameter int unsigned Width = CntWidth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/analog_weight_cfg.sv
// -----------------------------------------------------------------------------
// analog_weight_cfg
// Copies weight rows from wmem into the analog Ising macro. Each row is read,
// then written with a one-hot row-select pulse of H cycles followed by an L
// cycle settle phase. Configuration is latched on an accepted start.
//
// Interface contract: wmem_ren_o is a one-cycle request and wmem_rdata_i is
// taken exactly one cycle later (no back-pressure on either side); the macro
// treats analog_wen_o as a strobe qualifying analog_waddr_o/analog_wdata_o, and
// analog_waddr_o is non-zero (exactly one hot bit) only while analog_wen_o=1.
//
// Ports:
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   start_i              : start request, honoured only in IDLE
//   high_cycles_i        : write-enable high length (0 treated as 1)
//   low_cycles_i         : settle length (0 skips the LOW phase)
//   num_rows_i           : rows to program from row 0 (clamped to NumRows)
//   wmem_ren_o/raddr_o   : wmem read request / address (address holds)
//   wmem_rdata_i         : wmem read data, one cycle after the request
//   analog_wen_o/waddr_o : macro write strobe / one-hot row select
//   analog_wdata_o       : row data presented to the macro
//   busy_o, done_o       : busy outside IDLE, one-cycle completion pulse
//   state_o              : current sequencer state (debug)
//
// Build option: ANALOG_WCFG_PREFETCH_EN fetches row r+1 into a shadow register
// during row r's HIGH phase so later rows skip READ/LATCH.
// -----------------------------------------------------------------------------
module analog_weight_cfg
    import lagd_analog_pkg::*;
#(
    parameter int unsigned NumRows   = 256,
    parameter int unsigned DataWidth = 256,
    parameter int unsigned CntWidth  = lagd_analog_pkg::CntWidth,
    localparam int unsigned AddrWidth = $clog2(NumRows),
    localparam int unsigned NumWidth  = $clog2(NumRows + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [CntWidth-1:0]  high_cycles_i,
    input  logic [CntWidth-1:0]  low_cycles_i,
    input  logic [NumWidth-1:0]  num_rows_i,
    output logic                 wmem_ren_o,
    output logic [AddrWidth-1:0] wmem_raddr_o,
    input  logic [DataWidth-1:0] wmem_rdata_i,
    output logic                 analog_wen_o,
    output logic [NumRows-1:0]   analog_waddr_o,
    output logic [DataWidth-1:0] analog_wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output analog_wcfg_state_e   state_o
);

    analog_wcfg_state_e   state_q;
    logic [AddrWidth-1:0] row_q;
    logic [DataWidth-1:0] data_q;
    logic [CntWidth-1:0]  high_q, low_q;
    logic [NumWidth-1:0]  n_q, n_clamped;
    logic [CntWidth-1:0]  high_m1, low_m1, cnt_val;
    logic                 cnt_load, cnt_en, cnt_zero;
    logic                 last_row, go_low, row_done;
    logic [MaxRows-1:0]   onehot_cur;

    assign n_clamped  = (num_rows_i > NumWidth'(NumRows)) ? NumWidth'(NumRows) : num_rows_i;
    // Counters load length-1 so a phase lasts exactly its length; H=0 acts as 1.
    assign high_m1    = (high_q == '0) ? '0 : high_q - CntWidth'(1);
    assign low_m1     = (low_q == '0) ? '0 : low_q - CntWidth'(1);
    assign last_row   = ((NumWidth'(row_q) + NumWidth'(1)) == n_q);
    assign onehot_cur = row_onehot(row_idx_t'(row_q));

`ifdef ANALOG_WCFG_PREFETCH_EN
    logic [DataWidth-1:0] shadow_q;
    logic                 rd_valid_q;
    logic                 next_last;
    logic [MaxRows-1:0]   onehot_nxt;

    assign next_last  = ((NumWidth'(row_q) + NumWidth'(2)) == n_q);
    assign onehot_nxt = row_onehot(row_idx_t'(row_q + AddrWidth'(1)));
    // H+L=1 would switch rows before the prefetched data returns: stall one
    // LOW cycle (the counter loads low_m1=0) except after the last row.
    assign go_low     = (low_q != '0) || ((high_q <= CntWidth'(1)) && !last_row);
`else
    assign go_low     = (low_q != '0);
`endif

    assign row_done = cnt_zero && (((state_q == HIGH) && !go_low) || (state_q == LOW));
    assign cnt_en   = (state_q == HIGH) || (state_q == LOW);

    always_comb begin
        cnt_load = (state_q == LATCH) || ((state_q == HIGH) && cnt_zero && go_low);
        // The only load taken from HIGH is the move into LOW.
        cnt_val  = (state_q == HIGH) ? low_m1 : high_m1;
`ifdef ANALOG_WCFG_PREFETCH_EN
        if (row_done && !last_row) begin
            cnt_load = 1'b1;
            cnt_val  = high_m1;
        end
`endif
    end

    analog_phase_cnt #(
        .Width (CntWidth)
    ) u_phase_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Outputs are registered: each transition sets the values for the state
    // being entered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            row_q          <= '0;
            data_q         <= '0;
            high_q         <= '0;
            low_q          <= '0;
            n_q            <= '0;
            wmem_ren_o     <= 1'b0;
            wmem_raddr_o   <= '0;
            analog_wen_o   <= 1'b0;
            analog_waddr_o <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
`ifdef ANALOG_WCFG_PREFETCH_EN
            shadow_q       <= '0;
            rd_valid_q     <= 1'b0;
`endif
        end else begin
            wmem_ren_o     <= 1'b0;
            analog_wen_o   <= 1'b0;
            analog_waddr_o <= '0;
            done_o         <= 1'b0;
`ifdef ANALOG_WCFG_PREFETCH_EN
            rd_valid_q     <= wmem_ren_o;
            if (rd_valid_q) begin
                shadow_q <= wmem_rdata_i;
            end
`endif
            if (row_done) begin
                if (last_row) begin
                    state_q <= DONE;
                    done_o  <= 1'b1;
                end else begin
                    row_q <= row_q + AddrWidth'(1);
`ifdef ANALOG_WCFG_PREFETCH_EN
                    // Prefetched data may be arriving this very cycle.
                    data_q         <= rd_valid_q ? wmem_rdata_i : shadow_q;
                    state_q        <= HIGH;
                    analog_wen_o   <= 1'b1;
                    analog_waddr_o <= onehot_nxt[NumRows-1:0];
                    if (!next_last) begin
                        wmem_ren_o   <= 1'b1;
                        wmem_raddr_o <= row_q + AddrWidth'(2);
                    end
`else
                    state_q      <= READ;
                    wmem_ren_o   <= 1'b1;
                    wmem_raddr_o <= row_q + AddrWidth'(1);
`endif
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            high_q <= high_cycles_i;
                            low_q  <= low_cycles_i;
                            n_q    <= n_clamped;
                            row_q  <= '0;
                            busy_o <= 1'b1;
                            if (n_clamped != '0) begin
                                state_q      <= READ;
                                wmem_ren_o   <= 1'b1;
                                wmem_raddr_o <= '0;
                            end else begin
                                state_q <= DONE;
                                done_o  <= 1'b1;
                            end
                        end
                    end
                    READ: state_q <= LATCH;
                    LATCH: begin
                        data_q         <= wmem_rdata_i;
                        state_q        <= HIGH;
                        analog_wen_o   <= 1'b1;
                        analog_waddr_o <= onehot_cur[NumRows-1:0];
`ifdef ANALOG_WCFG_PREFETCH_EN
                        if (!last_row) begin
                            wmem_ren_o   <= 1'b1;
                            wmem_raddr_o <= row_q + AddrWidth'(1);
                        end
`endif
                    end
                    HIGH: begin
                        if (!cnt_zero) begin
                            analog_wen_o   <= 1'b1;
                            analog_waddr_o <= onehot_cur[NumRows-1:0];
                        end else begin
                            state_q <= LOW;
                        end
                    end
                    LOW: begin
                        // Wait for the counter; the row end is handled above.
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign analog_wdata_o = data_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_analog_weight_cfg.sv
module tb_analog_weight_cfg;
    import lagd_analog_pkg::*;

    localparam int NR = 256;
    localparam int DW = 256;
    localparam int CW = 32;
    localparam int AW = 8;
    localparam int NW = 9;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] high_cycles, low_cycles;
    logic [NW-1:0] num_rows;
    logic          wmem_ren;
    logic [AW-1:0] wmem_raddr;
    logic [DW-1:0] wmem_rdata = '0;
    logic          wen;
    logic [NR-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy, done;
    analog_wcfg_state_e dut_state;

    always #5 clk = ~clk;

    analog_weight_cfg dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .high_cycles_i  (high_cycles),
        .low_cycles_i   (low_cycles),
        .num_rows_i     (num_rows),
        .wmem_ren_o     (wmem_ren),
        .wmem_raddr_o   (wmem_raddr),
        .wmem_rdata_i   (wmem_rdata),
        .analog_wen_o   (wen),
        .analog_waddr_o (waddr),
        .analog_wdata_o (wdata),
        .busy_o         (busy),
        .done_o         (done),
        .state_o        (dut_state)
    );

    // wmem: one-cycle read latency
    logic [DW-1:0] mem [NR];
    always @(posedge clk) if (wmem_ren) wmem_rdata <= mem[wmem_raddr];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic          ren;
        logic [AW-1:0] raddr;
        logic          wen;
        logic [NR-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] m_raddr = '0;
    logic [DW-1:0] m_wdata = '0;
    int            errors = 0;
    int            checks = 0;
    int            run_id = 0;
    int            wen_cycles;
    logic [NR-1:0] last_waddr;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_cyc(input logic ren, input int rrow, input logic we, input int row,
                            input logic [DW-1:0] wd, input logic bz, input logic dn);
        exp_t e;
        if (ren) m_raddr = AW'(rrow);
        e.ren   = ren;
        e.raddr = m_raddr;
        e.wen   = we;
        e.waddr = we ? (NR'(1) << row) : '0;
        e.wdata = wd;
        e.busy  = bz;
        e.done  = dn;
        exp_q.push_back(e);
    endtask

    // Behavioural timeline of one sequence, cycle t+1 onward.
    task automatic build_model(input int h, input int l, input int n);
        int hh, nn;
        hh = (h == 0) ? 1 : h;
        nn = (n > NR) ? NR : n;
`ifdef ANALOG_WCFG_PREFETCH_EN
        if (nn > 0) begin
            push_cyc(1'b1, 0, 1'b0, 0, m_wdata, 1'b1, 1'b0);
            push_cyc(1'b0, 0, 1'b0, 0, m_wdata, 1'b1, 1'b0);
        end
        for (int r = 0; r < nn; r++) begin
            m_wdata = mem[r];
            for (int k = 0; k < hh; k++)
                push_cyc((k == 0) && (r < nn - 1), r + 1, 1'b1, r, m_wdata, 1'b1, 1'b0);
            repeat (l) push_cyc(1'b0, 0, 1'b0, 0, m_wdata, 1'b1, 1'b0);
            if ((hh + l == 1) && (r < nn - 1)) push_cyc(1'b0, 0, 1'b0, 0, m_wdata, 1'b1, 1'b0);
        end
`else
        for (int r = 0; r < nn; r++) begin
            push_cyc(1'b1, r, 1'b0, 0, m_wdata, 1'b1, 1'b0);
            push_cyc(1'b0, 0, 1'b0, 0, m_wdata, 1'b1, 1'b0);
            m_wdata = mem[r];
            repeat (hh) push_cyc(1'b0, 0, 1'b1, r, m_wdata, 1'b1, 1'b0);
            repeat (l) push_cyc(1'b0, 0, 1'b0, 0, m_wdata, 1'b1, 1'b0);
        end
`endif
        push_cyc(1'b0, 0, 1'b0, 0, m_wdata, 1'b1, 1'b1);
        push_cyc(1'b0, 0, 1'b0, 0, m_wdata, 1'b0, 1'b0);
    endtask

    // ---------------- driver ----------------
    // Called and returns at a negedge. abort_at >= 0 stops after that cycle.
    task automatic run_seq(input int h, input int l, input int n, input bit disturb,
                           input int abort_at, output int done_at);
        exp_t e;
        run_id++;
        exp_q.delete();
        build_model(h, l, n);
        high_cycles = CW'(h);
        low_cycles  = CW'(l);
        num_rows    = NW'(n);
        start       = 1'b1;
        done_at     = -1;
        wen_cycles  = 0;
        last_waddr  = '0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q[k];
            if (disturb && (k == 1 || k == 4) && e.busy) begin
                start       = 1'b1;
                high_cycles = CW'($urandom_range(0, 7));
                low_cycles  = CW'($urandom_range(0, 7));
                num_rows    = NW'($urandom_range(0, 9));
            end
            check($sformatf("r%0d c%0d ren", run_id, k + 1), DW'(wmem_ren), DW'(e.ren));
            check($sformatf("r%0d c%0d raddr", run_id, k + 1), DW'(wmem_raddr), DW'(e.raddr));
            check($sformatf("r%0d c%0d wen", run_id, k + 1), DW'(wen), DW'(e.wen));
            check($sformatf("r%0d c%0d waddr", run_id, k + 1), DW'(waddr), DW'(e.waddr));
            check($sformatf("r%0d c%0d wdata", run_id, k + 1), wdata, e.wdata);
            check($sformatf("r%0d c%0d busy", run_id, k + 1), DW'(busy), DW'(e.busy));
            check($sformatf("r%0d c%0d done", run_id, k + 1), DW'(done), DW'(e.done));
            if (done === 1'b1 && done_at < 0) done_at = k + 1;
            if (wen === 1'b1) begin
                wen_cycles++;
                last_waddr = waddr;
            end
            if (k == abort_at) break;
        end
        start = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int h;
        int l;
        int n;
        int exp_done;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int d;
        int abort_k;
`ifdef ANALOG_WCFG_PREFETCH_EN
        vecs[0] = '{3, 2, 2, 13};
        vecs[1] = '{0, 0, 1, 4};
        vecs[2] = '{0, 0, 0, 1};
        vecs[3] = '{1, 0, 3, 8};
        vecs[4] = '{2, 3, 1, 8};
        abort_k = 7;
`else
        vecs[0] = '{3, 2, 2, 15};
        vecs[1] = '{0, 0, 1, 4};
        vecs[2] = '{0, 0, 0, 1};
        vecs[3] = '{1, 0, 3, 10};
        vecs[4] = '{2, 3, 1, 8};
        abort_k = 9;
`endif
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < DW / 32; j++)
                mem[i][j*32 +: 32] = $urandom();
        mem[0] = {32{8'hA5}};
        mem[1] = {32{8'h5A}};

        rst_n = 1'b0;
        start = 1'b0;
        high_cycles = '0;
        low_cycles  = '0;
        num_rows    = '0;
        repeat (3) @(negedge clk);
        check("reset ren", DW'(wmem_ren), '0);
        check("reset raddr", DW'(wmem_raddr), '0);
        check("reset wen", DW'(wen), '0);
        check("reset waddr", DW'(waddr), '0);
        check("reset wdata", wdata, '0);
        check("reset busy", DW'(busy), '0);
        check("reset done", DW'(done), '0);
        check("reset state", DW'(dut_state), DW'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Table: full-trace check plus the completion cycle relative to start.
        for (int i = 0; i < 5; i++) begin
            run_seq(vecs[i].h, vecs[i].l, vecs[i].n, 1'b0, -1, d);
            check($sformatf("vec%0d done cycle", i), DW'(d), DW'(vecs[i].exp_done));
        end

        // More rows than the array holds: every row once, last select is the top row.
        run_seq(0, 0, NR + 5, 1'b0, -1, d);
        check("clamp rows written", DW'(wen_cycles), DW'(NR));
        check("clamp last waddr", DW'(last_waddr), DW'(NR'(1) << (NR - 1)));

        // Start re-pulsed and config changed mid-sequence: latched values rule.
        run_seq(3, 2, 2, 1'b1, -1, d);
        check("disturb done cycle", DW'(d), DW'(vecs[0].exp_done));

        // Reset in the first HIGH cycle of row 1: immediate abort, no done.
        run_seq(3, 2, 3, 1'b0, abort_k, d);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort ren", DW'(wmem_ren), '0);
        check("abort raddr", DW'(wmem_raddr), '0);
        check("abort wen", DW'(wen), '0);
        check("abort waddr", DW'(waddr), '0);
        check("abort wdata", wdata, '0);
        check("abort busy", DW'(busy), '0);
        check("abort done", DW'(done), '0);
        check("abort state", DW'(dut_state), DW'(IDLE));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("post-abort c%0d done", k), DW'(done), '0);
            check($sformatf("post-abort c%0d wen", k), DW'(wen), '0);
        end
        m_raddr = '0;
        m_wdata = '0;
        run_seq(1, 0, 2, 1'b0, -1, d);

        // Randomized sequences against the timeline model.
        for (int i = 0; i < 20; i++) begin
            run_seq($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 6),
                    1'($urandom_range(0, 1)), -1, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
